// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: weight-RAM driven MAC neuron with saturated output (NEURON_MAC_RELU_EN adds ReLU).
module neuron_mac_sequencer #(
    parameter int N_INPUTS = 16,
    parameter int ACC_W    = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic [5:0]  mem_address,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic [15:0] x_data,
    input  logic        x_valid,
    output logic        x_ready,
    output logic [31:0] y_data,
    output logic        y_valid,
    input  logic        y_ready
);
    typedef enum logic [1:0] {IDLE, BIAS, MAC, DONE} state_t;
    state_t state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [31:0] prod;
    logic [31:0] sat;
    logic ovf;

    assign prod = 32'($signed(mem_readdata[15:0])) * 32'($signed(x_data));
    // the accumulator fits in 32 bits only when everything above bit 31 is a copy of the sign
    assign ovf = !(&acc_q[ACC_W-1:31] || !(|acc_q[ACC_W-1:31]));
    assign sat = ovf ? (acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_q[31:0];
    assign busy = state_q != IDLE;
    assign y_valid = state_q == DONE;
    assign mem_write = 1'b0;
    assign mem_byteenable = 4'hF;
`ifdef NEURON_MAC_RELU_EN
    assign y_data = (y_valid && !sat[31]) ? sat : 32'h0;
`else
    assign y_data = y_valid ? sat : 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        acc_d = acc_q;
        mem_address = idx_q;
        mem_chipselect = 1'b0;
        x_ready = 1'b0;
        case (state_q)
            IDLE: begin
                mem_address = 6'(N_INPUTS);
                mem_chipselect = start;
                state_d = start ? BIAS : IDLE;
            end
            BIAS: begin
                acc_d = ACC_W'($signed(mem_readdata));
                idx_d = '0;
                mem_address = '0;
                mem_chipselect = 1'b1;
                state_d = MAC;
            end
            MAC: begin
                x_ready = 1'b1;
                mem_chipselect = 1'b1;
                if (x_valid) begin
                    acc_d = acc_q + ACC_W'(prod);
                    idx_d = idx_q + 6'd1;
                    mem_address = idx_q + 6'd1;
                    state_d = (idx_q == 6'(N_INPUTS - 1)) ? DONE : MAC;
                end
            end
            DONE: state_d = y_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            acc_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end
endmodule
